// File: rtl/sdu_spectrum_unloader.sv
// Unloads fft128 bins, converts them to saturated power and streams ping-pong spectral lines.
// Optional FFTSHIFT_EN: capture address = bin index XOR N/2 (DC at line_index N/2).
module sdu_spectrum_unloader #(
    parameter int N     = 128,
    parameter int IN_W  = 32,
    parameter int PWR_W = 32,
    parameter int SHIFT = 32,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fft_done,
    input  logic             fft_dv,
    input  logic [IDX_W-1:0] fft_xk_index,
    input  logic [IN_W-1:0]  fft_xk_re,
    input  logic [IN_W-1:0]  fft_xk_im,
    output logic             fft_unload,
    output logic             line_valid,
    input  logic             line_ready,
    output logic [PWR_W-1:0] line_data,
    output logic [IDX_W-1:0] line_index,
    output logic             line_last,
    output logic             busy
);
    localparam int SUM_W  = 2*IN_W + 1;
    localparam int ADDR_W = IDX_W + 1;

    typedef enum logic [1:0] {C_WAIT, C_UNLOAD, C_CAPTURE, C_DRAIN} cap_state_t;
    typedef enum logic {O_IDLE, O_STREAM} out_state_t;

    cap_state_t c_state, c_next;
    out_state_t o_state, o_next;

    logic [1:0]       full, full_next;
    logic             wr_bank, rd_bank;
    logic             pending, pending_next;
    logic             unload_next, take, cap_done, bank_avail;
    logic [IDX_W-1:0] bin_cnt, wr_idx;

    logic                    v1, v2, bank1, bank2;
    logic [IDX_W-1:0]        addr1, addr2;
    logic signed [2*IN_W-1:0] re_ext, im_ext;
    logic [2*IN_W-1:0]       sq_re, sq_im;
    logic [SUM_W-1:0]        sum, shifted;
    logic [PWR_W-1:0]        pwr, pwr2;

    logic [PWR_W-1:0]  mem [2*N];
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PWR_W-1:0]  rd_q;
    logic              out_valid, hs, line_done;
    logic [IDX_W-1:0]  out_idx;

`ifdef FFTSHIFT_EN
    assign wr_idx = fft_xk_index ^ IDX_W'(N/2);
`else
    assign wr_idx = fft_xk_index;
`endif

    assign hs        = out_valid & line_ready;
    assign line_done = hs && (out_idx == IDX_W'(N-1));
    // A bank freed by this cycle's final handshake is usable now, so the pending unload fires next cycle.
    assign bank_avail = !full[wr_bank] || (line_done && (rd_bank == wr_bank));

    always_comb begin
        c_next       = c_state;
        unload_next  = 1'b0;
        pending_next = pending | fft_done;
        take         = 1'b0;
        cap_done     = 1'b0;
        case (c_state)
            C_WAIT: if ((fft_done || pending) && bank_avail) begin
                unload_next  = 1'b1;
                pending_next = 1'b0;
                c_next       = C_UNLOAD;
            end
            C_UNLOAD: if (fft_dv) begin
                take   = 1'b1;
                c_next = C_CAPTURE;
            end
            C_CAPTURE: if (fft_dv) begin
                take = 1'b1;
                if (bin_cnt == IDX_W'(N-1)) c_next = C_DRAIN;
            end
            C_DRAIN: if (!v1) begin
                cap_done = 1'b1;
                c_next   = C_WAIT;
            end
            default: c_next = C_WAIT;
        endcase
    end

    always_comb begin
        full_next = full;
        if (line_done) full_next[rd_bank] = 1'b0;
        if (cap_done)  full_next[wr_bank] = 1'b1;
    end

    always_comb begin
        o_next  = o_state;
        rd_en   = 1'b0;
        rd_addr = {rd_bank, {IDX_W{1'b0}}};
        case (o_state)
            O_IDLE: if (full[rd_bank]) begin
                rd_en  = 1'b1;
                o_next = O_STREAM;
            end
            O_STREAM: if (line_done) begin
                o_next = O_IDLE;
            end else if (hs) begin
                rd_en   = 1'b1;
                rd_addr = {rd_bank, out_idx + 1'b1};
            end
            default: o_next = O_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_state    <= C_WAIT;
            o_state    <= O_IDLE;
            pending    <= 1'b0;
            fft_unload <= 1'b0;
            bin_cnt    <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            full       <= '0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
        end else begin
            c_state    <= c_next;
            o_state    <= o_next;
            pending    <= pending_next;
            fft_unload <= unload_next;
            full       <= full_next;
            if (unload_next)   bin_cnt <= '0;
            else if (take)     bin_cnt <= bin_cnt + 1'b1;
            if (cap_done)      wr_bank <= ~wr_bank;
            if (line_done)     rd_bank <= ~rd_bank;
            if (o_state == O_IDLE && o_next == O_STREAM) begin
                out_valid <= 1'b1;
                out_idx   <= '0;
            end else if (line_done) begin
                out_valid <= 1'b0;
            end else if (hs) begin
                out_idx <= out_idx + 1'b1;
            end
        end
    end

    assign re_ext  = {{IN_W{fft_xk_re[IN_W-1]}}, fft_xk_re};
    assign im_ext  = {{IN_W{fft_xk_im[IN_W-1]}}, fft_xk_im};
    assign sum     = {1'b0, sq_re} + {1'b0, sq_im};
    assign shifted = sum >> SHIFT;
    assign pwr     = (|shifted[SUM_W-1:PWR_W]) ? '1 : shifted[PWR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; v2 <= 1'b0; bank1 <= 1'b0; bank2 <= 1'b0;
            addr1 <= '0; addr2 <= '0; sq_re <= '0; sq_im <= '0; pwr2 <= '0;
        end else begin
            v1    <= take;
            bank1 <= wr_bank;
            addr1 <= wr_idx;
            sq_re <= re_ext * re_ext;
            sq_im <= im_ext * im_ext;
            v2    <= v1;
            bank2 <= bank1;
            addr2 <= addr1;
            pwr2  <= pwr;
        end
    end

    always_ff @(posedge clk) begin
        if (v2)    mem[{bank2, addr2}] <= pwr2;
        if (rd_en) rd_q <= mem[rd_addr];
    end

    assign line_valid = out_valid;
    assign line_index = out_idx;
    assign line_data  = out_valid ? rd_q : '0;
    assign line_last  = out_valid && (out_idx == IDX_W'(N-1));
    assign busy       = (c_state != C_WAIT) || (|full);

endmodule

// File: tb/tb_sdu_spectrum_unloader.sv
// Directed bench for sdu_spectrum_unloader: a SHIFT=32 instance plus a SHIFT=16 instance driven in lockstep.
module tb_sdu_spectrum_unloader;
    localparam int N = 128;
`ifdef FFTSHIFT_EN
    localparam int MASK = 64;
`else
    localparam int MASK = 0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, fft_done = 1'b0, fft_dv = 1'b0, line_ready = 1'b0;
    logic [6:0]  fft_xk_index = '0;
    logic [31:0] fft_xk_re = '0, fft_xk_im = '0;
    logic        fft_unload, line_valid, line_last, busy;
    logic [31:0] line_data;
    logic [6:0]  line_index;
    logic        s_unload, s_valid, s_last, s_busy;
    logic [31:0] s_data;
    logic [6:0]  s_index;

    int n_checks = 0, n_fail = 0;
    int unload_cnt = 0;
    int fre[N], fim[N];
    logic [31:0] exp_line[N], exp_a[N], exp_b[N], exp_c[N];
    logic [31:0] got_data[N], got_s[N];
    logic [6:0]  got_idx[N];
    logic        got_last[N];

    always #5 clk = ~clk;

    always @(negedge clk) if (fft_unload) unload_cnt <= unload_cnt + 1;

    sdu_spectrum_unloader #(.N(128), .IN_W(32), .PWR_W(32), .SHIFT(32)) dut (
        .clk(clk), .rst_n(rst_n), .fft_done(fft_done), .fft_dv(fft_dv),
        .fft_xk_index(fft_xk_index), .fft_xk_re(fft_xk_re), .fft_xk_im(fft_xk_im),
        .fft_unload(fft_unload), .line_valid(line_valid), .line_ready(line_ready),
        .line_data(line_data), .line_index(line_index), .line_last(line_last), .busy(busy));

    sdu_spectrum_unloader #(.N(128), .IN_W(32), .PWR_W(32), .SHIFT(16)) dut_s (
        .clk(clk), .rst_n(rst_n), .fft_done(fft_done), .fft_dv(fft_dv),
        .fft_xk_index(fft_xk_index), .fft_xk_re(fft_xk_re), .fft_xk_im(fft_xk_im),
        .fft_unload(s_unload), .line_valid(s_valid), .line_ready(line_ready),
        .line_data(s_data), .line_index(s_index), .line_last(s_last), .busy(s_busy));

    function automatic logic [31:0] pwr(input int re, input int im, input int sh);
        longint a, b;
        logic [64:0] s;
        a = longint'(re) * longint'(re);
        b = longint'(im) * longint'(im);
        s = {1'b0, a} + {1'b0, b};
        s = s >> sh;
        return (s[64:32] != 0) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                1: begin fre[i] = (i+1)*37*65536;     fim[i] = -(11*i+5)*65536;     end
                2: begin fre[i] = -(3*i+1)*20*65536;  fim[i] = 7*i*65536 + 12345;   end
                3: begin fre[i] = i*5*65536 + 7;      fim[i] = 3*65536;             end
                default: begin fre[i] = 0; fim[i] = 0; end
            endcase
        end
        for (int p = 0; p < N; p++) exp_line[p] = pwr(fre[p ^ MASK], fim[p ^ MASK], 32);
    endtask

    task automatic pulse_done();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
    endtask

    task automatic wait_unload(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (fft_unload) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic drive_bins(input int nb, input int gap_after);
        for (int i = 0; i < nb; i++) begin
            fft_dv = 1'b1; fft_xk_index = 7'(i); fft_xk_re = fre[i]; fft_xk_im = fim[i];
            tick();
            if (i == gap_after) begin
                fft_dv = 1'b0;
                repeat (3) tick();
            end
        end
        fft_dv = 1'b0; fft_xk_re = '0; fft_xk_im = '0; fft_xk_index = '0;
    endtask

    // Records every handshake; counts cycles where a stalled word changed.
    task automatic stream_line(input int random_ready, input int budget, output int nhs, output int unstable);
        bit stalled, rdy;
        logic [31:0] hd;
        logic [6:0] hi;
        logic hl;
        nhs = 0; unstable = 0; stalled = 1'b0; hd = '0; hi = '0; hl = 1'b0;
        for (int c = 0; c < budget && nhs < N; c++) begin
            if (line_valid) begin
                if (stalled && (line_data !== hd || line_index !== hi || line_last !== hl)) unstable++;
                rdy = (random_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rdy) begin
                    got_data[nhs] = line_data; got_idx[nhs] = line_index;
                    got_last[nhs] = line_last; got_s[nhs] = s_data;
                    nhs++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1; hd = line_data; hi = line_index; hl = line_last;
                end
                line_ready = rdy;
            end else begin
                stalled = 1'b0;
                line_ready = 1'b0;
            end
            tick();
        end
        line_ready = 1'b0;
    endtask

    task automatic test_reset();
        fft_done = 1'b1;
        repeat (3) tick();
        n_checks++; if (fft_unload !== 1'b0) begin n_fail++; $display("FAIL reset_unload: got %b expected 0", fft_unload); end
        n_checks++; if (line_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", line_valid); end
        n_checks++; if (line_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", line_data); end
        n_checks++; if (line_index !== 7'h0) begin n_fail++; $display("FAIL reset_index: got %h expected 0", line_index); end
        n_checks++; if (line_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", line_last); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        fft_done = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_impulse();
        bit ok;
        int nhs, uns, base, nz;
        set_frame(0);
        fre[0] = 327680;
        base = unload_cnt;
        pulse_done();
        wait_unload(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL impulse_unload_timeout: got none expected pulse"); end
        drive_bins(N, -1);
        repeat (3) tick();
        stream_line(0, 400, nhs, uns);
        n_checks++; if (nhs != N) begin n_fail++; $display("FAIL impulse_count: got %0d expected %0d", nhs, N); end
        n_checks++; if (got_data[MASK] !== 32'd25) begin n_fail++; $display("FAIL impulse_dc: got %0d expected 25", got_data[MASK]); end
        n_checks++; if (got_idx[MASK] !== 7'(MASK)) begin n_fail++; $display("FAIL impulse_dc_index: got %0d expected %0d", got_idx[MASK], MASK); end
        nz = 0;
        for (int p = 0; p < N; p++) if (p != MASK && got_data[p] !== 32'h0) nz++;
        n_checks++; if (nz != 0) begin n_fail++; $display("FAIL impulse_other_bins: got %0d nonzero expected 0", nz); end
        n_checks++; if (unload_cnt - base != 1) begin n_fail++; $display("FAIL impulse_unload_count: got %0d expected 1", unload_cnt - base); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int nhs, uns;
        set_frame(1);
        pulse_done();
        wait_unload(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_unload_timeout: got none expected pulse"); end
        drive_bins(N, -1);
        repeat (3) tick();
        stream_line(1, 2000, nhs, uns);
        n_checks++; if (nhs != N) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", nhs, N); end
        n_checks++; if (uns != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", uns); end
        for (int k = 0; k < nhs; k++) begin
            n_checks++; if (got_data[k] !== exp_line[k]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", k, got_data[k], exp_line[k]); end
            n_checks++; if (got_idx[k] !== 7'(k)) begin n_fail++; $display("FAIL bp_index[%0d]: got %0d expected %0d", k, got_idx[k], k); end
            n_checks++; if (got_last[k] !== (k == N-1)) begin n_fail++; $display("FAIL bp_last[%0d]: got %b expected %b", k, got_last[k], k == N-1); end
        end
    endtask

    task automatic test_both_full();
        bit ok;
        int nhs, uns, base;
        set_frame(1); exp_a = exp_line;
        pulse_done(); wait_unload(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_unload_a: got none expected pulse"); end
        drive_bins(N, -1);
        repeat (3) tick();
        set_frame(2); exp_b = exp_line;
        pulse_done(); wait_unload(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_unload_b: got none expected pulse"); end
        drive_bins(N, -1);
        repeat (3) tick();
        base = unload_cnt;
        pulse_done();
        repeat (15) tick();
        n_checks++; if (unload_cnt != base) begin n_fail++; $display("FAIL full_withheld: got %0d pulses expected 0", unload_cnt - base); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b expected 1", busy); end
        n_checks++; if (line_valid !== 1'b1 || line_index !== 7'd0) begin n_fail++; $display("FAIL full_stalled_head: got valid=%b index=%0d expected valid=1 index=0", line_valid, line_index); end
        stream_line(0, 400, nhs, uns);
        n_checks++; if (fft_unload !== 1'b1) begin n_fail++; $display("FAIL full_unload_after_last: got %b expected 1", fft_unload); end
        set_frame(3); exp_c = exp_line;
        n_checks++; if (nhs != N) begin n_fail++; $display("FAIL full_count_a: got %0d expected %0d", nhs, N); end
        for (int k = 0; k < N; k++) begin
            n_checks++; if (got_data[k] !== exp_a[k]) begin n_fail++; $display("FAIL full_data_a[%0d]: got %h expected %h", k, got_data[k], exp_a[k]); end
        end
        fft_dv = 1'b1; fft_xk_index = 7'd0; fft_xk_re = fre[0]; fft_xk_im = fim[0];
        tick();
        n_checks++; if (fft_unload !== 1'b0) begin n_fail++; $display("FAIL full_unload_width: got %b expected 0", fft_unload); end
        for (int i = 1; i < N; i++) begin
            fft_xk_index = 7'(i); fft_xk_re = fre[i]; fft_xk_im = fim[i];
            tick();
        end
        fft_dv = 1'b0;
        repeat (3) tick();
        stream_line(0, 400, nhs, uns);
        n_checks++; if (nhs != N) begin n_fail++; $display("FAIL full_count_b: got %0d expected %0d", nhs, N); end
        for (int k = 0; k < N; k++) begin
            n_checks++; if (got_data[k] !== exp_b[k]) begin n_fail++; $display("FAIL full_data_b[%0d]: got %h expected %h", k, got_data[k], exp_b[k]); end
        end
        stream_line(0, 400, nhs, uns);
        n_checks++; if (nhs != N) begin n_fail++; $display("FAIL full_count_c: got %0d expected %0d", nhs, N); end
        for (int k = 0; k < N; k++) begin
            n_checks++; if (got_data[k] !== exp_c[k]) begin n_fail++; $display("FAIL full_data_c[%0d]: got %h expected %h", k, got_data[k], exp_c[k]); end
        end
    endtask

    task automatic test_saturation();
        bit ok;
        int nhs, uns;
        set_frame(0);
        fre[0] = 32'h8000_0000; fim[0] = 32'h8000_0000; fre[1] = 32'h0000_0100;
        pulse_done(); wait_unload(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_unload_timeout: got none expected pulse"); end
        drive_bins(N, -1);
        repeat (3) tick();
        stream_line(0, 400, nhs, uns);
        n_checks++; if (nhs != N) begin n_fail++; $display("FAIL sat_count: got %0d expected %0d", nhs, N); end
        n_checks++; if (got_s[MASK] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_clip_s16: got %h expected ffffffff", got_s[MASK]); end
        n_checks++; if (got_s[1 ^ MASK] !== 32'h1) begin n_fail++; $display("FAIL sat_small_s16: got %h expected 00000001", got_s[1 ^ MASK]); end
        n_checks++; if (got_data[MASK] !== 32'h8000_0000) begin n_fail++; $display("FAIL sat_max_s32: got %h expected 80000000", got_data[MASK]); end
        n_checks++; if (got_data[1 ^ MASK] !== 32'h0) begin n_fail++; $display("FAIL sat_small_s32: got %h expected 00000000", got_data[1 ^ MASK]); end
    endtask

    task automatic test_dv_gaps();
        bit ok;
        int nhs, uns;
        set_frame(3);
        pulse_done(); wait_unload(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL gap_unload_timeout: got none expected pulse"); end
        drive_bins(N, 40);
        repeat (3) tick();
        stream_line(0, 400, nhs, uns);
        n_checks++; if (nhs != N) begin n_fail++; $display("FAIL gap_count: got %0d expected %0d", nhs, N); end
        for (int k = 0; k < N; k++) begin
            n_checks++; if (got_data[k] !== exp_line[k]) begin n_fail++; $display("FAIL gap_data[%0d]: got %h expected %h", k, got_data[k], exp_line[k]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int nhs, uns, seen;
        set_frame(2);
        pulse_done(); wait_unload(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_unload_timeout: got none expected pulse"); end
        drive_bins(60, -1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_async: got %b expected 0", busy); end
        n_checks++; if (line_valid !== 1'b0 || fft_unload !== 1'b0 || line_data !== 32'h0) begin n_fail++; $display("FAIL rmid_outputs_async: got valid=%b unload=%b data=%h expected all 0", line_valid, fft_unload, line_data); end
        tick(); tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin tick(); if (line_valid) seen++; end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rmid_no_line: got %0d valid cycles expected 0", seen); end
        pulse_done(); wait_unload(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_next_unload: got none expected pulse"); end
        drive_bins(N, -1);
        repeat (3) tick();
        stream_line(0, 400, nhs, uns);
        n_checks++; if (nhs != N) begin n_fail++; $display("FAIL rmid_count: got %0d expected %0d", nhs, N); end
        for (int k = 0; k < N; k++) begin
            n_checks++; if (got_data[k] !== exp_line[k]) begin n_fail++; $display("FAIL rmid_data[%0d]: got %h expected %h", k, got_data[k], exp_line[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_backpressure();
        test_both_full();
        test_saturation();
        test_dv_gaps();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
